// File: rtl/minibyte_bus_responder.sv
// Memory-mapped responder for the minibyte CPU: 32x8 RAM, GPIO and an optional reload timer.
// The timer block is compiled in only when MINIBYTE_RESPONDER_TIMER_EN is defined.
module minibyte_bus_responder (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  input  logic       we_in,
  output logic [7:0] data_out,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       timer_tick_out
);

  localparam logic [7:0] ADDR_GPIO_OUT = 8'hF0;
  localparam logic [7:0] ADDR_GPIO_IN  = 8'hF1;

  logic [7:0] ram [32];
  logic [7:0] gpo;
  logic [7:0] sync1;
  logic [7:0] sync2;
  logic       ram_sel;
  logic [7:0] rd_data;

  assign ram_sel = (addr_in[7:5] == 3'b000);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < 32; i++) begin
        ram[i] <= '0;
      end
    end else if (we_in && ram_sel) begin
      ram[addr_in[4:0]] <= data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      gpo <= '0;
    end else if (we_in && (addr_in == ADDR_GPIO_OUT)) begin
      gpo <= data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

  assign gpio_out = gpo;

`ifdef MINIBYTE_RESPONDER_TIMER_EN
  localparam logic [7:0] ADDR_TIMER_CNT    = 8'hF2;
  localparam logic [7:0] ADDR_TIMER_RELOAD = 8'hF3;
  localparam logic [7:0] ADDR_TIMER_CTRL   = 8'hF4;
  localparam logic [7:0] ADDR_TIMER_STAT   = 8'hF5;

  logic [7:0] cnt;
  logic [7:0] reload;
  logic       enable;
  logic       expired;
  logic       ctrl_wr;
  logic       enable_rise;
  logic       expire;
  logic       stat_clear;

  assign ctrl_wr     = we_in && (addr_in == ADDR_TIMER_CTRL);
  assign enable_rise = ctrl_wr && data_in[0] && !enable;
  // Expiry is decided by the current enable, so the edge that disables the timer still completes its step.
  assign expire      = enable && (cnt == '0);
  assign stat_clear  = we_in && (addr_in == ADDR_TIMER_STAT) && data_in[0];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt <= '0;
    end else if (enable_rise || expire) begin
      cnt <= reload;
    end else if (enable) begin
      cnt <= cnt - 8'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      reload <= '0;
    end else if (we_in && (addr_in == ADDR_TIMER_RELOAD)) begin
      reload <= data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      enable <= 1'b0;
    end else if (ctrl_wr) begin
      enable <= data_in[0];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      expired <= 1'b0;
    end else if (expire) begin
      expired <= 1'b1;
    end else if (stat_clear) begin
      expired <= 1'b0;
    end
  end

  assign timer_tick_out = expire;
`else
  assign timer_tick_out = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    if (ram_sel) begin
      rd_data = ram[addr_in[4:0]];
    end else begin
      case (addr_in)
        ADDR_GPIO_OUT:     rd_data = gpo;
        ADDR_GPIO_IN:      rd_data = sync2;
`ifdef MINIBYTE_RESPONDER_TIMER_EN
        ADDR_TIMER_CNT:    rd_data = cnt;
        ADDR_TIMER_RELOAD: rd_data = reload;
        ADDR_TIMER_CTRL:   rd_data = {7'd0, enable};
        ADDR_TIMER_STAT:   rd_data = {7'd0, expired};
`endif
        default:           rd_data = '0;
      endcase
    end
  end

  assign data_out = rd_data;

endmodule

// File: tb/tb_minibyte_bus_responder.sv
// Self-checking bench for minibyte_bus_responder against a memory-map reference model.
// Timer expectations follow MINIBYTE_RESPONDER_TIMER_EN as seen by this compilation.
module tb_minibyte_bus_responder;

`ifdef MINIBYTE_RESPONDER_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] addr_in;
  logic [7:0] data_in;
  logic       we_in;
  logic [7:0] data_out;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       timer_tick_out;

  int checks = 0;
  int errors = 0;

  // Reference state: the architectural contents of the memory map.
  logic [7:0] m_ram [32];
  logic [7:0] m_gpo, m_s1, m_s2, m_cnt, m_rel;
  logic       m_en, m_exp;

  minibyte_bus_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .addr_in        (addr_in),
    .data_in        (data_in),
    .we_in          (we_in),
    .data_out       (data_out),
    .gpio_in        (gpio_in),
    .gpio_out       (gpio_out),
    .timer_tick_out (timer_tick_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a < 8'd32) return m_ram[a[4:0]];
    case (a)
      8'hF0: return m_gpo;
      8'hF1: return m_s2;
      8'hF2: return TIMER_ON ? m_cnt : 8'h00;
      8'hF3: return TIMER_ON ? m_rel : 8'h00;
      8'hF4: return TIMER_ON ? {7'd0, m_en} : 8'h00;
      8'hF5: return TIMER_ON ? {7'd0, m_exp} : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic m_tick();
    return TIMER_ON && m_en && (m_cnt == 8'd0);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_ram[i] = 8'h00;
    m_gpo = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0; m_rel = 0; m_en = 0; m_exp = 0;
  endtask

  // Advance one clock edge, updating the model from the inputs held across that edge.
  task automatic step();
    logic [7:0] a, d, g, ncnt, nrel;
    logic       w, nen, nexp;
    a = addr_in; d = data_in; w = we_in; g = gpio_in;
    ncnt = m_cnt; nrel = m_rel; nen = m_en; nexp = m_exp;
    if (TIMER_ON) begin
      if (w && a == 8'hF4 && d[0] && !m_en) ncnt = m_rel;
      else if (m_en) ncnt = (m_cnt == 8'd0) ? m_rel : m_cnt - 8'd1;
      if (w && a == 8'hF5 && d[0]) nexp = 1'b0;
      if (m_en && m_cnt == 8'd0) nexp = 1'b1;
      if (w && a == 8'hF3) nrel = d;
      if (w && a == 8'hF4) nen = d[0];
    end
    @(posedge clk_in);
    #1;
    if (w && a < 8'd32) m_ram[a[4:0]] = d;
    if (w && a == 8'hF0) m_gpo = d;
    m_s2 = m_s1; m_s1 = g;
    m_cnt = ncnt; m_rel = nrel; m_en = nen; m_exp = nexp;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr_in = a; data_in = d; we_in = 1'b1;
    step();
    we_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] addrs [6];
    addrs = '{8'h00, 8'h1F, 8'hF0, 8'hF1, 8'hF2, 8'hF5};
    rst_in = 1'b0; we_in = 0; addr_in = 0; data_in = 0; gpio_in = 0;
    #2;
    m_reset();
    checks++;
    if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio_out got=%h exp=00", gpio_out); end
    checks++;
    if (timer_tick_out !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", timer_tick_out); end
    foreach (addrs[i]) begin
      addr_in = addrs[i];
      #1;
      checks++;
      if (data_out !== 8'h00) begin
        errors++; $display("FAIL reset_read addr=%h got=%h exp=00", addrs[i], data_out);
      end
    end
    #3 rst_in = 1'b1;
    bus_write(8'h10, 8'h99);
    addr_in = 8'h10;
    #1;
    checks++;
    if (data_out !== 8'h99) begin errors++; $display("FAIL first_write got=%h exp=99", data_out); end
  endtask

  task automatic test_ram();
    logic [7:0] addrs [4];
    logic [7:0] exps  [4];
    logic [7:0] old;
    addrs = '{8'h07, 8'h1F, 8'h20, 8'hE0};
    exps  = '{8'hA5, 8'h3C, 8'h00, 8'h00};
    bus_write(8'h07, 8'hA5);
    bus_write(8'h1F, 8'h3C);
    bus_write(8'h20, 8'h77);
    bus_write(8'hE0, 8'h55);
    foreach (addrs[i]) begin
      addr_in = addrs[i];
      #1;
      checks++;
      if (data_out !== exps[i]) begin
        errors++; $display("FAIL ram_fixed addr=%h got=%h exp=%h", addrs[i], data_out, exps[i]);
      end
    end
    // Read during write must still show the old contents.
    old = m_read(8'h07);
    addr_in = 8'h07; data_in = 8'h11; we_in = 1'b1;
    #1;
    checks++;
    if (data_out !== old) begin errors++; $display("FAIL read_during_write got=%h exp=%h", data_out, old); end
    step();
    we_in = 1'b0;
    for (int i = 0; i < 40; i++) bus_write(8'($urandom_range(0, 31)), 8'($urandom));
    for (int i = 0; i < 32; i++) begin
      addr_in = 8'(i);
      #1;
      checks++;
      if (data_out !== m_read(8'(i))) begin
        errors++; $display("FAIL ram_rand addr=%h got=%h exp=%h", i, data_out, m_read(8'(i)));
      end
    end
  endtask

  task automatic test_gpio();
    bus_write(8'hF0, 8'h81);
    checks++;
    if (gpio_out !== 8'h81) begin errors++; $display("FAIL gpio_out got=%h exp=81", gpio_out); end
    gpio_in = 8'h5A; addr_in = 8'hF1;
    #1;
    checks++;
    if (data_out !== m_read(8'hF1)) begin errors++; $display("FAIL gpio_in_0 got=%h exp=%h", data_out, m_read(8'hF1)); end
    step();
    checks++;
    if (data_out !== m_read(8'hF1)) begin errors++; $display("FAIL gpio_in_1 got=%h exp=%h", data_out, m_read(8'hF1)); end
    step();
    checks++;
    if (data_out !== 8'h5A) begin errors++; $display("FAIL gpio_in_2 got=%h exp=5a", data_out); end
  endtask

  task automatic test_timer();
    int ticks = 0;
    logic [7:0] exp_cnt;
    bus_write(8'hF3, 8'h03);
    bus_write(8'hF4, 8'h01);
    addr_in = 8'hF2;
    for (int k = 0; k < 12; k++) begin
      #1;
      exp_cnt = TIMER_ON ? 8'(3 - (k % 4)) : 8'h00;
      checks++;
      if (data_out !== exp_cnt || data_out !== m_read(8'hF2)) begin
        errors++; $display("FAIL timer_cnt k=%0d got=%h exp=%h", k, data_out, exp_cnt);
      end
      checks++;
      if (timer_tick_out !== m_tick()) begin
        errors++; $display("FAIL timer_tick k=%0d got=%b exp=%b", k, timer_tick_out, m_tick());
      end
      if (timer_tick_out === 1'b1) ticks++;
      step();
    end
    checks++;
    if (ticks != (TIMER_ON ? 3 : 0)) begin errors++; $display("FAIL timer_tick_count got=%0d exp=%0d", ticks, TIMER_ON ? 3 : 0); end
    addr_in = 8'hF5;
    #1;
    checks++;
    if (data_out !== (TIMER_ON ? 8'h01 : 8'h00)) begin errors++; $display("FAIL timer_stat got=%h exp=%h", data_out, TIMER_ON ? 8'h01 : 8'h00); end
  endtask

  task automatic test_stat_clear();
    int n;
    n = 0;
    addr_in = 8'hF2;
    while (!(m_en && m_cnt == 8'd2) && n < 10) begin step(); n++; end
    bus_write(8'hF5, 8'h01);
    addr_in = 8'hF5;
    #1;
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL stat_clear_idle got=%h exp=00", data_out); end
    n = 0;
    while (!m_tick() && n < 10) begin step(); n++; end
    #1;
    checks++;
    if (timer_tick_out !== m_tick()) begin errors++; $display("FAIL stat_tick_align got=%b exp=%b", timer_tick_out, m_tick()); end
    bus_write(8'hF5, 8'h01);
    addr_in = 8'hF5;
    #1;
    checks++;
    if (data_out !== (TIMER_ON ? 8'h01 : 8'h00)) begin errors++; $display("FAIL stat_clear_vs_expiry got=%h exp=%h", data_out, TIMER_ON ? 8'h01 : 8'h00); end
    bus_write(8'hF5, 8'h00);
    #1;
    checks++;
    if (data_out !== m_read(8'hF5)) begin errors++; $display("FAIL stat_write0 got=%h exp=%h", data_out, m_read(8'hF5)); end
    bus_write(8'hF5, 8'h01);
    #1;
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL stat_clear_later got=%h exp=00", data_out); end
  endtask

  task automatic test_random();
    logic [7:0] a, d;
    int unsigned r;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) a = 8'($urandom_range(0, 31));
      else if (r < 8) a = 8'hF0 + 8'($urandom_range(0, 5));
      else a = 8'($urandom);
      d = 8'($urandom);
      if (a == 8'hF3) d = 8'($urandom_range(0, 5));
      addr_in = a; data_in = d; we_in = ($urandom_range(0, 2) == 0);
      gpio_in = 8'($urandom);
      #1;
      checks++;
      if (data_out !== m_read(a)) begin errors++; $display("FAIL rand_read k=%0d addr=%h got=%h exp=%h", k, a, data_out, m_read(a)); end
      checks++;
      if (gpio_out !== m_gpo) begin errors++; $display("FAIL rand_gpio_out k=%0d got=%h exp=%h", k, gpio_out, m_gpo); end
      checks++;
      if (timer_tick_out !== m_tick()) begin errors++; $display("FAIL rand_tick k=%0d got=%b exp=%b", k, timer_tick_out, m_tick()); end
      step();
    end
    we_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus_write(8'hF0, 8'hC3);
    bus_write(8'h05, 8'h6E);
    bus_write(8'hF3, 8'h04);
    bus_write(8'hF4, 8'h00);
    bus_write(8'hF4, 8'h01);
    step(); step();
    #2;
    rst_in = 1'b0;
    #1;
    m_reset();
    checks++;
    if (gpio_out !== 8'h00) begin errors++; $display("FAIL midreset_gpio_out got=%h exp=00", gpio_out); end
    for (int i = 0; i < 40; i++) begin
      addr_in = (i < 32) ? 8'(i) : 8'hF0 + 8'(i - 32);
      #1;
      checks++;
      if (data_out !== 8'h00) begin errors++; $display("FAIL midreset_read addr=%h got=%h exp=00", addr_in, data_out); end
      checks++;
      if (timer_tick_out !== 1'b0) begin errors++; $display("FAIL midreset_tick got=%b exp=0", timer_tick_out); end
    end
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    addr_in = 8'hF2;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (timer_tick_out !== 1'b0 || data_out !== 8'h00) begin
        errors++; $display("FAIL postreset_idle k=%0d tick=%b cnt=%h exp tick=0 cnt=00", k, timer_tick_out, data_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio();
    test_timer();
    test_stat_clear();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
